ps2_matrix_kbd: RTL and testbench

Parametrised PS/2-to-matrix keyboard emulator and successor to the fixed 12x7 Laser 500 matrix. It consumes the byte stream from ps2_intf and decodes prefixes (E0, F0, E1 pause) with a sequence FSM. Codes are translated through a runtime-loadable keymap RAM into a ROWS x COLS active-low matrix, read by the video/IO chip via active-low row selects. It adds pause-sequence reset pulsing, error/BAT recovery, prefix timeout and a registered-readout option.

---
 rtl/ps2_kbd_pkg.sv | 20 ++
 rtl/ps2_keymap_ram.sv | 18 +
 rtl/ps2_matrix_kbd.sv | 119 +++++++++++
 tb/tb_ps2_matrix_kbd.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: PS/2 prefix bytes, pause sequence, decoder states and keymap entry field widths
package ps2_kbd_pkg;
  localparam logic [7:0] E0 = 8'hE0;
  localparam logic [7:0] F0 = 8'hF0;
  localparam logic [7:0] E1 = 8'hE1;
  localparam logic [7:0] BAT = 8'hAA;
  localparam logic [7:0] ERR0 = 8'h00;
  localparam logic [7:0] ERR1 = 8'hFF;
  localparam logic [7:0] PAUSE_SEQ [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  typedef enum logic [2:0] {IDLE, EXT, REL, EXT_REL, PAUSE} state_t;
  function automatic int row_w(input int rows);
    return rows > 1 ? $clog2(rows) : 1;
  endfunction
  function automatic int col_w(input int cols);
    return cols > 1 ? $clog2(cols) : 1;
  endfunction
  function automatic int map_w(input int rows, input int cols);
    return 1 + row_w(rows) + col_w(cols);
  endfunction
endpackage

// File: rtl/ps2_keymap_ram.sv
// ps2_keymap_ram: 512 x W keymap (clk; we/waddr/wdata write; raddr in, rdata out next cycle, old data on collision)
module ps2_keymap_ram #(
  parameter int W = 8,
  parameter string INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         we,
  input  logic [8:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [8:0]   raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [512];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ps2_matrix_kbd.sv
// ps2_matrix_kbd: PS/2 bytes (ps2_byte/valid/error) -> keymap -> active-low ROWSxCOLS matrix read as kd via row_sel; reset_key pulse on pause; map_we/addr/wdata load keymap
module ps2_matrix_kbd
  import ps2_kbd_pkg::*;
#(
  parameter int    ROWS        = 12,
  parameter int    COLS        = 7,
  parameter int    RESET_PULSE = 1000000,
  parameter int    TIMEOUT     = 2000000,
  parameter bit    READ_REG    = 1'b0,
  parameter string INIT_FILE   = "keymap.hex"
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   ps2_byte,
  input  logic                         ps2_valid,
  input  logic                         ps2_error,
  input  logic [ROWS-1:0]              row_sel,
  output logic [COLS-1:0]              kd,
  output logic                         reset_key,
  input  logic                         map_we,
  input  logic [8:0]                   map_addr,
  input  logic [map_w(ROWS, COLS)-1:0] map_wdata
);
  localparam int RB = row_w(ROWS);
  localparam int CB = col_w(COLS);
  localparam int MW = 1 + RB + CB;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(RESET_PULSE + 1);
  state_t state, state_n;
  logic [2:0] pidx, pidx_n;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] pcnt;
  logic ev, ev_ext, ev_brk, fire, bad, hit;
  logic s2_v, s2_brk;
  logic [MW-1:0] ent;
  logic [RB-1:0] ent_row;
  logic [CB-1:0] ent_col;
  logic [ROWS-1:0][COLS-1:0] mat;
  logic [COLS-1:0] kd_c, kd_q;
  assign bad = ps2_error | (ps2_valid & (ps2_byte == ERR0 | ps2_byte == ERR1 | ps2_byte == BAT));
  always_comb begin
    state_n = state;
    pidx_n = pidx;
    ev = 1'b0;
    ev_ext = 1'b0;
    ev_brk = 1'b0;
    fire = 1'b0;
    if (bad) state_n = IDLE;
    else if (ps2_valid)
      case (state)
        IDLE: begin
          state_n = ps2_byte == E0 ? EXT : ps2_byte == F0 ? REL : ps2_byte == E1 ? PAUSE : IDLE;
          pidx_n = 3'd1;
          ev = ps2_byte != E0 && ps2_byte != F0 && ps2_byte != E1;
        end
        EXT: begin
          state_n = ps2_byte == F0 ? EXT_REL : IDLE;
          ev = ps2_byte != F0;
          ev_ext = 1'b1;
        end
        REL: begin
          state_n = IDLE;
          ev = 1'b1;
          ev_brk = 1'b1;
        end
        EXT_REL: begin
          state_n = IDLE;
          ev = 1'b1;
          ev_ext = 1'b1;
          ev_brk = 1'b1;
        end
        PAUSE: begin
          state_n = ps2_byte == PAUSE_SEQ[pidx] && pidx != 3'd7 ? PAUSE : IDLE;
          pidx_n = pidx + 3'd1;
          fire = ps2_byte == PAUSE_SEQ[pidx] && pidx == 3'd7;
        end
        default: state_n = IDLE;
      endcase
    else if (state != IDLE && tcnt == TW'(TIMEOUT - 1)) state_n = IDLE;
  end
  ps2_keymap_ram #(.W(MW), .INIT_FILE(INIT_FILE)) u_ram (
    .clk(clk),
    .we(map_we),
    .waddr(map_addr),
    .wdata(map_wdata),
    .raddr({ev_ext, ps2_byte}),
    .rdata(ent)
  );
  assign ent_row = ent[CB +: RB];
  assign ent_col = ent[CB-1:0];
  assign hit = s2_v & ent[MW-1] & (int'(ent_row) < ROWS) & (int'(ent_col) < COLS);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pidx <= '0;
      tcnt <= '0;
      pcnt <= '0;
      s2_v <= 1'b0;
      s2_brk <= 1'b0;
      mat <= '1;
      kd_q <= '1;
    end else begin
      state <= state_n;
      pidx <= pidx_n;
      tcnt <= (ps2_valid || state_n == IDLE) ? '0 : tcnt + 1'b1;
      pcnt <= fire ? PW'(RESET_PULSE) : pcnt != '0 ? pcnt - 1'b1 : pcnt;
      s2_v <= ev;
      s2_brk <= ev_brk;
      if (bad) mat <= '1;
      else if (hit) mat[ent_row][ent_col] <= s2_brk;
      kd_q <= kd_c;
    end
  always_comb begin
    kd_c = '1;
    for (int r = 0; r < ROWS; r++) kd_c &= row_sel[r] ? '1 : mat[r];
  end
  assign kd = READ_REG ? kd_q : kd_c;
  assign reset_key = pcnt != '0;
endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// tb_ps2_matrix_kbd: directed plus randomized check of ps2_matrix_kbd (combinational and registered readout) against a byte-grammar model
module tb_ps2_matrix_kbd;
  localparam int RP = 16;
  localparam int TO = 100;
  logic clk = 1'b0, reset_n = 1'b1, ps2_valid = 1'b0, ps2_error = 1'b0, map_we = 1'b0;
  logic [7:0] ps2_byte = '0, map_wdata = '0;
  logic [8:0] map_addr = '0;
  logic [11:0] row_sel = '1;
  logic [6:0] kd0, kd1;
  logic rk0, rk1;
  int checks = 0, errors = 0;
  logic [6:0] m [12];
  logic [7:0] km [512];
  logic [7:0] hist [$];
  logic [7:0] pseq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] codes [5] = '{8'h1A, 8'h1C, 8'h75, 8'h14, 8'h77};
  logic pv = 1'b0, pmk = 1'b0;
  int pr = 0, pc = 0, pk = 0, idle = 0, hi;
  always #5 clk = ~clk;
  ps2_matrix_kbd #(.ROWS(12), .COLS(7), .RESET_PULSE(RP), .TIMEOUT(TO), .READ_REG(1'b0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset_n(reset_n), .ps2_byte(ps2_byte), .ps2_valid(ps2_valid), .ps2_error(ps2_error),
    .row_sel(row_sel), .kd(kd0), .reset_key(rk0), .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata)
  );
  ps2_matrix_kbd #(.ROWS(12), .COLS(7), .RESET_PULSE(RP), .TIMEOUT(TO), .READ_REG(1'b1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset_n(reset_n), .ps2_byte(ps2_byte), .ps2_valid(ps2_valid), .ps2_error(ps2_error),
    .row_sel(row_sel), .kd(kd1), .reset_key(rk1), .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  function automatic logic [6:0] rd(input logic [11:0] rs);
    logic [6:0] k = '1;
    for (int r = 0; r < 12; r++) if (!rs[r]) k &= m[r];
    return k;
  endfunction
  // The model keeps the raw bytes of an unfinished key code and reads the code as a whole once it is complete.
  task automatic feed(input logic [7:0] b, output logic ev, output logic ext, output logic brk, output logic pz);
    int n;
    ev = 1'b0; ext = 1'b0; brk = 1'b0; pz = 1'b0;
    hist.push_back(b);
    n = hist.size();
    if (hist[0] == 8'hE1) begin
      if (b != pseq[n-1]) hist.delete();
      else if (n == 8) begin pz = 1'b1; hist.delete(); end
    end else if (!((b == 8'hE0 && n == 1) || (b == 8'hF0 && (n == 1 || (n == 2 && hist[0] == 8'hE0))))) begin
      ext = hist[0] == 8'hE0;
      brk = n >= 2 && hist[n-2] == 8'hF0;
      ev = 1'b1;
      hist.delete();
    end
  endtask
  task automatic step(input logic v, input logic [7:0] b, input logic er);
    logic isbad, ev, ext, brk, pz;
    logic [7:0] e;
    logic [6:0] kd1e;
    ps2_valid = v; ps2_byte = b; ps2_error = er;
    kd1e = rd(row_sel);
    isbad = er || (v && (b == 8'h00 || b == 8'hFF || b == 8'hAA));
    pz = 1'b0;
    if (isbad) begin
      for (int r = 0; r < 12; r++) m[r] = '1;
      hist.delete(); pv = 1'b0; idle = 0;
    end else begin
      if (pv) m[pr][pc] = !pmk;
      pv = 1'b0;
      if (v) begin
        idle = 0;
        feed(b, ev, ext, brk, pz);
        e = km[{ext, b}];
        if (ev && e[7] && e[6:3] < 12 && e[2:0] < 7) begin
          pv = 1'b1; pr = int'(e[6:3]); pc = int'(e[2:0]); pmk = !brk;
        end
      end else if (hist.size() != 0) begin
        idle++;
        if (idle == TO) begin hist.delete(); idle = 0; end
      end
    end
    pk = pz ? RP : pk > 0 ? pk - 1 : 0;
    if (map_we) km[map_addr] = map_wdata;
    @(posedge clk); #1;
    chk("kd", kd0, rd(row_sel));
    chk("kd_reg", kd1, kd1e);
    chk("reset_key", rk0, pk != 0);
    chk("reset_key_reg", rk1, pk != 0);
    ps2_valid = 1'b0; ps2_error = 1'b0; map_we = 1'b0;
  endtask
  task automatic keys(input logic [63:0] s, input int n);
    for (int i = 0; i < n; i++) step(1'b1, s[8*(n-1-i) +: 8], 1'b0);
  endtask
  task automatic wait_n(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask
  task automatic set_map(input logic [8:0] a, input logic [7:0] d);
    map_we = 1'b1; map_addr = a; map_wdata = d;
    step(1'b0, 8'h00, 1'b0);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    for (int r = 0; r < 12; r++) m[r] = '1;
    hist.delete(); pv = 1'b0; pk = 0; idle = 0;
    chk("rst_kd", kd0, 7'h7F);
    chk("rst_kd_reg", kd1, 7'h7F);
    chk("rst_reset_key", rk0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask
  initial begin
    #1;
    do_reset();
    for (int a = 0; a < 512; a++) set_map(9'(a), 8'($urandom));
    set_map(9'h01A, 8'h85);
    set_map(9'h175, 8'hD3);
    set_map(9'h01C, 8'hAA);
    set_map(9'h11A, 8'h98);
    row_sel = ~12'h001;
    keys(64'h1A, 1); chk("make_lat1", kd0, 7'h7F);
    wait_n(1); chk("make_kd", kd0, 7'h5F); chk("make_kd_reg_lag", kd1, 7'h7F);
    wait_n(1); chk("make_kd_reg", kd1, 7'h5F);
    keys(64'hF01A, 2); chk("brk_lat1", kd0, 7'h5F);
    wait_n(1); chk("brk_kd", kd0, 7'h7F);
    keys(64'h1A, 1); keys(64'hE075, 2); wait_n(2);
    row_sel = ~12'h401; wait_n(1); chk("two_rows", kd0, 7'h57);
    row_sel = ~12'h400; wait_n(1); chk("ext_make", kd0, 7'h77);
    keys(64'hE0F075, 3); wait_n(2); chk("ext_brk", kd0, 7'h7F);
    row_sel = ~12'h001;
    keys(64'hE11477E1F014F077, 8);
    hi = 0;
    repeat (20) begin
      if (rk0) hi++;
      step(1'b0, 8'h00, 1'b0);
    end
    chk("pulse_len", hi, RP);
    chk("pause_matrix", kd0, 7'h5F);
    keys(64'hE11413, 3); chk("bad_pause_nopulse", rk0, 1'b0);
    keys(64'hF01A, 2); wait_n(2); chk("bad_pause_idle", kd0, 7'h7F);
    row_sel = 12'h000;
    keys(64'h1A, 1); keys(64'hE075, 2); keys(64'h1C, 1); wait_n(2);
    chk("three_keys", kd0, 7'h53);
    keys(64'hE0, 1); step(1'b0, 8'h00, 1'b1); chk("err_clear", kd0, 7'h7F);
    keys(64'h1A, 1); wait_n(2); chk("err_then_make", kd0, 7'h5F);
    keys(64'hE075, 2); keys(64'h1C, 1); wait_n(2);
    keys(64'hE0, 1); keys(64'hAA, 1); chk("bat_clear", kd0, 7'h7F);
    keys(64'h1A, 1); wait_n(2); chk("bat_then_make", kd0, 7'h5F);
    keys(64'hE075, 2); wait_n(2); keys(64'hE0, 1);
    do_reset();
    keys(64'h1A, 1); wait_n(2); chk("rst_then_make", kd0, 7'h5F);
    step(1'b0, 8'h00, 1'b1);
    row_sel = ~12'h009;
    keys(64'hE0, 1); wait_n(TO); keys(64'h1A, 1); wait_n(2);
    chk("timeout_make", kd0, 7'h5F);
    step(1'b0, 8'h00, 1'b1);
    keys(64'hE0, 1); wait_n(TO - 1); keys(64'h1A, 1); wait_n(2);
    chk("no_timeout_ext", kd0, 7'h7E);
    step(1'b0, 8'h00, 1'b1);
    row_sel = ~12'h005;
    map_we = 1'b1; map_addr = 9'h01A; map_wdata = 8'h91;
    step(1'b1, 8'h1A, 1'b0); wait_n(2); chk("old_map", kd0, 7'h5F);
    keys(64'h1A, 1); wait_n(1); chk("new_map", kd0, 7'h5D); chk("new_map_reg_lag", kd1, 7'h5F);
    wait_n(1); chk("new_map_reg", kd1, 7'h5D);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic [7:0] b;
      if ($urandom_range(0, 9) == 0) row_sel = 12'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        map_we = 1'b1; map_addr = 9'($urandom); map_wdata = 8'($urandom);
      end
      k = $urandom_range(0, 15);
      b = k == 0 ? 8'hE0 : k == 1 ? 8'hF0 : k == 2 ? 8'hE1 : k < 10 ? codes[$urandom_range(0, 4)] : 8'($urandom);
      if ($urandom_range(0, 199) == 0) keys(64'hE11477E1F014F077, 8);
      else if ($urandom_range(0, 99) == 0) step(1'b0, 8'h00, 1'b1);
      else if ($urandom_range(0, 3) == 0) step(1'b0, 8'h00, 1'b0);
      else step(1'b1, b, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
